// File: rtl/pc_pkg.sv
// Shared encodings for the next-PC unit: branch funct3 codes and the
// next-PC source select.
package pc_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JAL,
        SEL_JALR,
        SEL_PEND,
        SEL_TRAP
    } pc_sel_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps funct3 and the ALU compare flags to a
// taken decision. Purely combinational.
module branch_cond
    import pc_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = i_zero;
            F3_BNE:  o_taken = ~i_zero;
            F3_BLT:  o_taken = i_lt;
            F3_BGE:  o_taken = ~i_lt;
            F3_BLTU: o_taken = i_ltu;
            F3_BGEU: o_taken = ~i_ltu;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC generator: owns the PC register, selects trap/JALR/JAL/branch/pending/
// sequential sources. Optional macro PC_NEXT_MISALIGN_TRAP_EN rejects targets with bit 1 set.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch,
    input  logic            jump,
    input  logic            jalr,
    input  logic [2:0]      br_funct3,
    input  logic            zero,
    input  logic            lt,
    input  logic            ltu,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] alu_result,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            redirect,
    output logic            misalign
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_target;
    logic            r_pend_valid;
    logic            r_redirect;
    logic            r_misalign;

    logic            w_taken;
    logic            w_live;
    logic [XLEN-1:0] w_live_target;
    logic [XLEN-1:0] w_jalr_target;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    pc_sel_t         w_sel;

    branch_cond u_branch_cond (
        .i_funct3 (br_funct3),
        .i_zero   (zero),
        .i_lt     (lt),
        .i_ltu    (ltu),
        .o_taken  (w_taken)
    );

    assign w_pc_plus4    = r_pc + PC_STEP;
    assign w_jalr_target = {alu_result[XLEN-1:1], 1'b0};
    assign w_live        = jalr | jump | (branch & w_taken);

    // Live request target in its own priority order; also what gets parked while stalled.
    always_comb begin
        w_live_target = jump_target;
        if (jalr) begin
            w_live_target = w_jalr_target;
        end
    end

    always_comb begin
        w_sel = SEL_SEQ;
        if (trap_valid) begin
            w_sel = SEL_TRAP;
        end else if (jalr) begin
            w_sel = SEL_JALR;
        end else if (jump) begin
            w_sel = SEL_JAL;
        end else if (branch && w_taken) begin
            w_sel = SEL_BR;
        end else if (r_pend_valid) begin
            w_sel = SEL_PEND;
        end
    end

    always_comb begin
        w_target = w_pc_plus4;
        case (w_sel)
            SEL_TRAP: w_target = trap_vector;
            SEL_JALR: w_target = w_jalr_target;
            SEL_JAL:  w_target = jump_target;
            SEL_BR:   w_target = jump_target;
            SEL_PEND: w_target = r_pend_target;
            default:  w_target = w_pc_plus4;
        endcase
    end

`ifdef PC_NEXT_MISALIGN_TRAP_EN
    assign w_misaligned = (w_sel != SEL_SEQ) && (w_sel != SEL_TRAP) && w_target[1];
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_VECTOR;
            r_pend_target <= '0;
            r_pend_valid  <= 1'b0;
            r_redirect    <= 1'b0;
            r_misalign    <= 1'b0;
        end else if (trap_valid) begin
            r_pc         <= trap_vector;
            r_pend_valid <= 1'b0;
            r_redirect   <= 1'b1;
            r_misalign   <= 1'b0;
        end else if (stall) begin
            // Park the newest request; it is applied once the stall releases.
            if (w_live) begin
                r_pend_target <= w_live_target;
                r_pend_valid  <= 1'b1;
            end
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_sel == SEL_SEQ) begin
            r_pc       <= w_pc_plus4;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_misaligned) begin
            r_pend_valid <= 1'b0;
            r_redirect   <= 1'b0;
            r_misalign   <= 1'b1;
        end else begin
            r_pc         <= w_target;
            r_pend_valid <= 1'b0;
            r_redirect   <= 1'b1;
            r_misalign   <= 1'b0;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign redirect = r_redirect;
`ifdef PC_NEXT_MISALIGN_TRAP_EN
    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: reset, branch conditions, priority,
// stall/pending behaviour, trap, async reset and PC wraparound.
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  br_funct3;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic [31:0] jump_target;
    logic [31:0] alu_result;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .jalr        (jalr),
        .br_funct3   (br_funct3),
        .zero        (zero),
        .lt          (lt),
        .ltu         (ltu),
        .jump_target (jump_target),
        .alu_result  (alu_result),
        .trap_valid  (trap_valid),
        .trap_vector (trap_vector),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .redirect    (redirect),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t pc=%h redirect=%b misalign=%b", $time, pc, redirect, misalign);
    endtask

    task automatic idle();
        stall       = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        jalr        = 1'b0;
        br_funct3   = 3'b000;
        zero        = 1'b0;
        lt          = 1'b0;
        ltu         = 1'b0;
        jump_target = '0;
        alu_result  = '0;
        trap_valid  = 1'b0;
        trap_vector = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #12;
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++;
        if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
        checks++;
        if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h4) begin errors++; $display("FAIL seq_first got=%h exp=%h", pc, 32'h4); end
        tick();
        checks++;
        if (pc !== 32'h8 || redirect !== 1'b0) begin
            errors++; $display("FAIL seq_second got=%h/%b exp=%h/0", pc, redirect, 32'h8);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3_v   [8] = '{3'b001, 3'b000, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
        logic       zero_v [8] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1};
        logic       lt_v   [8] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b1};
        logic       ltu_v  [8] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1};
        logic       tkn_v  [8] = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0};
        logic [31:0] exp_pc;
        // BNE with zero=0: taken to 0x100, redirect for exactly one cycle
        branch = 1'b1; br_funct3 = 3'b001; zero = 1'b0; jump_target = 32'h100;
        tick();
        checks++;
        if (pc !== 32'h100 || redirect !== 1'b1) begin
            errors++; $display("FAIL bne_taken got=%h/%b exp=%h/1", pc, redirect, 32'h100);
        end
        idle();
        tick();
        checks++;
        if (pc !== 32'h104 || redirect !== 1'b0) begin
            errors++; $display("FAIL bne_after got=%h/%b exp=%h/0", pc, redirect, 32'h104);
        end
        exp_pc = 32'h104;
        for (int i = 0; i < 8; i++) begin
            branch = 1'b1; br_funct3 = f3_v[i]; zero = zero_v[i]; lt = lt_v[i]; ltu = ltu_v[i];
            jump_target = 32'h300 + 32'(i) * 32'h10;
            exp_pc = tkn_v[i] ? jump_target : exp_pc + 32'h4;
            tick();
            checks++;
            if (pc !== exp_pc || redirect !== tkn_v[i]) begin
                errors++;
                $display("FAIL branch_vec%0d got=%h/%b exp=%h/%b", i, pc, redirect, exp_pc, tkn_v[i]);
            end
        end
        idle();
    endtask

    task automatic test_priority();
        jalr = 1'b1; jump = 1'b1; alu_result = 32'h203; jump_target = 32'h400;
        tick();
        checks++;
        if (pc !== 32'h202 || redirect !== 1'b1) begin
            errors++; $display("FAIL jalr_over_jal got=%h/%b exp=%h/1", pc, redirect, 32'h202);
        end
        jalr = 1'b0; branch = 1'b1; br_funct3 = 3'b000; zero = 1'b1; jump_target = 32'h480;
        tick();
        checks++;
        if (pc !== 32'h480) begin errors++; $display("FAIL jal_over_branch got=%h exp=%h", pc, 32'h480); end
        jalr = 1'b1; trap_valid = 1'b1; trap_vector = 32'h1000;
        tick();
        checks++;
        if (pc !== 32'h1000 || redirect !== 1'b1) begin
            errors++; $display("FAIL trap_over_all got=%h/%b exp=%h/1", pc, redirect, 32'h1000);
        end
        idle();
    endtask

    task automatic test_stall();
        logic [31:0] held;
        tick();
        held = pc;
        stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
        tick();
        checks++;
        if (pc !== held || redirect !== 1'b0) begin
            errors++; $display("FAIL stall_hold1 got=%h/%b exp=%h/0", pc, redirect, held);
        end
        jump = 1'b0;
        tick();
        checks++;
        if (pc !== held) begin errors++; $display("FAIL stall_hold2 got=%h exp=%h", pc, held); end
        stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h80 || redirect !== 1'b1) begin
            errors++; $display("FAIL pending_apply got=%h/%b exp=%h/1", pc, redirect, 32'h80);
        end
        tick();
        checks++;
        if (pc !== 32'h84 || redirect !== 1'b0) begin
            errors++; $display("FAIL pending_done got=%h/%b exp=%h/0", pc, redirect, 32'h84);
        end
        // Live request in the release cycle beats the pending one
        stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
        tick();
        stall = 1'b0; jump_target = 32'hC0;
        tick();
        checks++;
        if (pc !== 32'hC0 || redirect !== 1'b1) begin
            errors++; $display("FAIL live_beats_pending got=%h/%b exp=%h/1", pc, redirect, 32'hC0);
        end
        jump = 1'b0;
        tick();
        checks++;
        if (pc !== 32'hC4) begin errors++; $display("FAIL pending_dropped got=%h exp=%h", pc, 32'hC4); end
        // A later request while stalled overwrites the parked one
        stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
        tick();
        jump = 1'b0; jalr = 1'b1; alu_result = 32'h91;
        tick();
        jalr = 1'b0; stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h90) begin errors++; $display("FAIL pending_overwrite got=%h exp=%h", pc, 32'h90); end
        idle();
    endtask

    task automatic test_trap();
        stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
        tick();
        jump = 1'b0; trap_valid = 1'b1; trap_vector = 32'h1C0;
        tick();
        checks++;
        if (pc !== 32'h1C0 || redirect !== 1'b1) begin
            errors++; $display("FAIL trap_in_stall got=%h/%b exp=%h/1", pc, redirect, 32'h1C0);
        end
        trap_valid = 1'b0; stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h1C4 || redirect !== 1'b0) begin
            errors++; $display("FAIL trap_clears_pending got=%h/%b exp=%h/0", pc, redirect, 32'h1C4);
        end
        idle();
    endtask

    task automatic test_async_reset();
        stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
        tick();
        jump = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || redirect !== 1'b0) begin
            errors++; $display("FAIL async_reset got=%h/%b exp=%h/0", pc, redirect, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h4 || redirect !== 1'b0) begin
            errors++; $display("FAIL reset_clears_pending got=%h/%b exp=%h/0", pc, redirect, 32'h4);
        end
        idle();
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        checks++;
        if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL pc_plus4_wrap got=%h exp=%h", pc_plus4, 32'h0); end
        tick();
        checks++;
        if (pc !== 32'h0 || redirect !== 1'b0) begin
            errors++; $display("FAIL pc_wrap got=%h/%b exp=%h/0", pc, redirect, 32'h0);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] held;
        held = pc;
        jump = 1'b1; jump_target = 32'h102;
        tick();
        jump = 1'b0;
`ifdef PC_NEXT_MISALIGN_TRAP_EN
        checks++;
        if (pc !== held || misalign !== 1'b1 || redirect !== 1'b0) begin
            errors++; $display("FAIL misalign_on got=%h/%b/%b exp=%h/1/0", pc, misalign, redirect, held);
        end
        tick();
        checks++;
        if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_pulse got=%b exp=0", misalign); end
`else
        checks++;
        if (pc !== 32'h102 || misalign !== 1'b0 || redirect !== 1'b1) begin
            errors++; $display("FAIL misalign_off got=%h/%b/%b exp=%h/0/1", pc, misalign, redirect, 32'h102);
        end
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_priority();
        test_stall();
        test_trap();
        test_async_reset();
        test_wrap();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
